// File: rtl/mem_lsu_pkg.sv
// Shared opcode encodings and access-size helpers for the load/store unit.
// The opcode values mirror the EXE_* entries of the core's defines.vh.
package mem_lsu_pkg;

    localparam logic [5:0] EXE_LB  = 6'b100000;
    localparam logic [5:0] EXE_LH  = 6'b100001;
    localparam logic [5:0] EXE_LW  = 6'b100011;
    localparam logic [5:0] EXE_LBU = 6'b100100;
    localparam logic [5:0] EXE_LHU = 6'b100101;
    localparam logic [5:0] EXE_SB  = 6'b101000;
    localparam logic [5:0] EXE_SH  = 6'b101001;
    localparam logic [5:0] EXE_SW  = 6'b101011;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    function automatic acc_size_t op_size(input logic [5:0] op);
        case (op)
            EXE_LB, EXE_LBU, EXE_SB: op_size = SZ_BYTE;
            EXE_LH, EXE_LHU, EXE_SH: op_size = SZ_HALF;
            default:                 op_size = SZ_WORD;
        endcase
    endfunction

    // Byte accesses can never be misaligned.
    function automatic logic is_misaligned(input acc_size_t size, input logic [1:0] off);
        case (size)
            SZ_HALF: is_misaligned = off[0];
            SZ_WORD: is_misaligned = |off;
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword from an SRAM word and sign- or
// zero-extends it according to the load opcode.
module lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        case (i_op)
            EXE_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            EXE_LBU: o_data = {24'b0, w_byte};
            EXE_LH:  o_data = {{16{w_half[15]}}, w_half};
            EXE_LHU: o_data = {16'b0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: same-cycle byte-enabled stores, stalled loads with a
// fixed SRAM read latency, and address-error detection for misaligned accesses.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        memwrite,
    input  logic        memtoreg,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        lsu_stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr
);

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_LOAD_WAIT = 1'b1;
    localparam logic [2:0] LAT_INIT     = 3'(RD_LATENCY);

    logic [0:0] r_state;
    logic [2:0] r_cnt;
    logic [5:0] r_op;
    logic [1:0] r_off;

    logic       w_accept;
    logic       w_misal;
    logic       w_do_store;
    logic       w_do_load;
    logic       w_wait;
    logic [2:0] w_cnt_dec;
    acc_size_t  w_size;

    // A decoder asserting both controls is treated as a store.
    assign w_size     = op_size(op);
    assign w_misal    = is_misaligned(w_size, addr[1:0]);
    assign w_accept   = (r_state == ST_IDLE) & req_valid & (memwrite | memtoreg);
    assign w_do_store = w_accept & memwrite & ~w_misal;
    assign w_do_load  = w_accept & ~memwrite & ~w_misal;
    assign w_wait     = (r_state == ST_LOAD_WAIT);
    assign w_cnt_dec  = r_cnt - 3'd1;

    assign adel     = w_accept & w_misal & ~memwrite;
    assign ades     = w_accept & w_misal & memwrite;
    assign badvaddr = (adel | ades) ? addr : 32'b0;
    assign ld_valid = w_wait & (w_cnt_dec == 3'd0);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'b0;
        data_sram_wdata = 32'b0;
        lsu_stall       = 1'b0;
        if (w_do_store) begin
            data_sram_en   = 1'b1;
            data_sram_addr = addr;
            case (w_size)
                SZ_BYTE: begin
                    data_sram_wen   = 4'b0001 << addr[1:0];
                    data_sram_wdata = {4{wdata_in[7:0]}};
                end
                SZ_HALF: begin
                    data_sram_wen   = addr[1] ? 4'b1100 : 4'b0011;
                    data_sram_wdata = {2{wdata_in[15:0]}};
                end
                default: begin
                    data_sram_wen   = 4'b1111;
                    data_sram_wdata = wdata_in;
                end
            endcase
        end else if (w_do_load) begin
            data_sram_en   = 1'b1;
            data_sram_addr = addr;
            lsu_stall      = 1'b1;
        end else if (w_wait) begin
            lsu_stall = (w_cnt_dec != 3'd0);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_op    <= 6'd0;
            r_off   <= 2'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_do_load) begin
                r_state <= ST_LOAD_WAIT;
                r_cnt   <= LAT_INIT;
                r_op    <= op;
                r_off   <= addr[1:0];
            end
        end else begin
            r_cnt <= w_cnt_dec;
            if (w_cnt_dec == 3'd0) begin
                r_state <= ST_IDLE;
            end
        end
    end

    lsu_load_align u_load_align (
        .i_op   (r_op),
        .i_off  (r_off),
        .i_word (data_sram_rdata),
        .o_data (ld_data)
    );

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a byte-level reference memory predicts every
// SRAM transaction, address error and load result; a monitor compares them.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int LAT = 3;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        memwrite;
    logic        memtoreg;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        lsu_stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;

    mem_lsu #(.RD_LATENCY(LAT)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .memwrite        (memwrite),
        .memtoreg        (memtoreg),
        .op              (op),
        .addr            (addr),
        .wdata_in        (wdata_in),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .lsu_stall       (lsu_stall),
        .ld_valid        (ld_valid),
        .ld_data         (ld_data),
        .adel            (adel),
        .ades            (ades),
        .badvaddr        (badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: synchronous write, read data valid LAT cycles after issue.
    bit   [31:0] sram [bit [31:0]];
    logic [31:0] rd_pipe [LAT];

    always @(posedge clk) begin
        bit [31:0] k;
        bit [31:0] w;
        k = data_sram_addr >> 2;
        if (data_sram_en && data_sram_wen != 4'b0) begin
            w = sram.exists(k) ? sram[k] : 32'b0;
            for (int i = 0; i < 4; i++)
                if (data_sram_wen[i]) w[8*i +: 8] = data_sram_wdata[8*i +: 8];
            sram[k] = w;
        end
        if (data_sram_en && data_sram_wen == 4'b0)
            rd_pipe[0] <= sram.exists(k) ? sram[k] : 32'b0;
        else
            rd_pipe[0] <= $urandom();
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign data_sram_rdata = rd_pipe[LAT-1];

    // Reference model: little-endian byte memory and expectation queues.
    typedef struct { logic [31:0] addr; logic [3:0] wen; logic [31:0] wdata; } wr_t;
    typedef struct { logic st; logic [31:0] addr; } err_t;

    bit [7:0]    ref_mem [bit [31:0]];
    wr_t         exp_wr [$];
    logic [31:0] exp_rd [$];
    logic [31:0] exp_ld [$];
    err_t        exp_err [$];

    function automatic bit [7:0] ref_byte(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [5:0] o);
        if (o == EXE_LB || o == EXE_LBU || o == EXE_SB) return 1;
        if (o == EXE_LH || o == EXE_LHU || o == EXE_SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] o, input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = ref_byte(a);
        h = {ref_byte(a + 1), ref_byte(a)};
        case (o)
            EXE_LB:  return 32'($signed(b));
            EXE_LBU: return 32'(b);
            EXE_LH:  return 32'($signed(h));
            EXE_LHU: return 32'(h);
            default: return {ref_byte(a + 3), ref_byte(a + 2), h};
        endcase
    endfunction

    function automatic void expect_req(input logic rv, input logic mw, input logic mr,
                                       input logic [5:0] o, input logic [31:0] a,
                                       input logic [31:0] wd);
        int  n;
        wr_t w;
        err_t e;
        if (!(rv && (mw || mr))) return;
        n = nbytes(o);
        if (a % n != 0) begin
            e.st = mw;
            e.addr = a;
            exp_err.push_back(e);
            return;
        end
        if (mw) begin
            w.addr = a;
            case (n)
                1: begin w.wen = 4'(1 << a[1:0]); w.wdata = {4{wd[7:0]}}; end
                2: begin w.wen = 4'(3 << a[1:0]); w.wdata = {2{wd[15:0]}}; end
                default: begin w.wen = 4'hF; w.wdata = wd; end
            endcase
            for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
            exp_wr.push_back(w);
        end else begin
            exp_rd.push_back(a);
            exp_ld.push_back(ref_load(o, a));
        end
    endfunction

    // Monitor: every observable DUT event must match the head of its queue.
    int stall_run = 0;
    int rd_count = 0;
    int wr_count = 0;
    int ld_count = 0;
    int last_ldv_cyc = 0;
    int last_wr_cyc = 0;

    always @(negedge clk) begin
        wr_t  w;
        err_t e;
        logic [31:0] v;
        if (!resetn) begin
            stall_run = 0;
        end else begin
            if (data_sram_en && data_sram_wen != 4'b0) begin
                wr_count++;
                last_wr_cyc = cyc;
                check("wr_expected", exp_wr.size() != 0, 1'b1);
                if (exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    check("wr_addr", data_sram_addr, w.addr);
                    check("wr_wen", data_sram_wen, w.wen);
                    check("wr_wdata", data_sram_wdata, w.wdata);
                    check("wr_stall", lsu_stall, 1'b0);
                end
            end else if (data_sram_en) begin
                rd_count++;
                check("rd_expected", exp_rd.size() != 0, 1'b1);
                if (exp_rd.size() != 0) begin
                    v = exp_rd.pop_front();
                    check("rd_addr", data_sram_addr, v);
                    check("rd_stall", lsu_stall, 1'b1);
                end
            end
            if (adel || ades) begin
                check("err_expected", exp_err.size() != 0, 1'b1);
                if (exp_err.size() != 0) begin
                    e = exp_err.pop_front();
                    check("adel", adel, !e.st);
                    check("ades", ades, e.st);
                    check("badvaddr", badvaddr, e.addr);
                    check("err_en", data_sram_en, 1'b0);
                    check("err_wen", data_sram_wen, 4'b0);
                    check("err_stall", lsu_stall, 1'b0);
                end
            end
            if (ld_valid) begin
                ld_count++;
                last_ldv_cyc = cyc;
                check("ld_expected", exp_ld.size() != 0, 1'b1);
                if (exp_ld.size() != 0) begin
                    v = exp_ld.pop_front();
                    check("ld_data", ld_data, v);
                    check("ld_stall_cycles", stall_run, LAT);
                    check("ld_stall_low", lsu_stall, 1'b0);
                end
            end
            stall_run = lsu_stall ? stall_run + 1 : 0;
        end
    end

    task automatic drive(input logic rv, input logic mw, input logic mr,
                         input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd);
        req_valid = rv;
        memwrite  = mw;
        memtoreg  = mr;
        op        = o;
        addr      = a;
        wdata_in  = wd;
    endtask

    // Presents a request like the EX stage: held until a cycle ends without stall.
    task automatic issue(input logic rv, input logic mw, input logic mr,
                         input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd);
        logic st;
        bit   done;
        expect_req(rv, mw, mr, o, a, wd);
        drive(rv, mw, mr, o, a, wd);
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            st = lsu_stall;
            @(posedge clk);
            #1;
            done = !st;
        end
        check("issue_complete", done, 1'b1);
    endtask

    task automatic issue_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd);
        logic st_op;
        st_op = (o == EXE_SB || o == EXE_SH || o == EXE_SW);
        issue(1'b1, st_op, !st_op, o, a, wd);
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [5:0] ops [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  rd0, wr0, ld0, kind, n;
        bit  seen;
        logic [5:0]  o;
        logic [31:0] a;
        logic        is_st;

        ops[0] = EXE_LB; ops[1] = EXE_LBU; ops[2] = EXE_LH; ops[3] = EXE_LHU;
        ops[4] = EXE_LW; ops[5] = EXE_SB;  ops[6] = EXE_SH; ops[7] = EXE_SW;

        resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", data_sram_en, 1'b0);
        check("rst_wen", data_sram_wen, 4'b0);
        check("rst_stall", lsu_stall, 1'b0);
        check("rst_ld_valid", ld_valid, 1'b0);
        check("rst_adel", adel, 1'b0);
        check("rst_ades", ades, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        issue_op(EXE_SB, 32'h1003, 32'h0000_00AB);
        issue_op(EXE_SW, 32'h2000, 32'h0000_F300);
        issue_op(EXE_LB, 32'h2001, 32'h0);
        issue_op(EXE_LBU, 32'h2001, 32'h0);
        issue_op(EXE_SW, 32'h2000, 32'h8001_1234);
        issue_op(EXE_LH, 32'h2002, 32'h0);
        issue_op(EXE_LHU, 32'h2000, 32'h0);
        issue_op(EXE_LW, 32'h3002, 32'h0);
        issue_op(EXE_SH, 32'h3001, 32'h1234_5678);
        issue_op(EXE_SW, 32'h3003, 32'h1234_5678);
        idle_cycle();

        // LW followed by an SW that is held on the inputs throughout the load.
        rd0 = rd_count;
        wr0 = wr_count;
        expect_req(1'b1, 1'b0, 1'b1, EXE_LW, 32'h2000, 32'h0);
        drive(1'b1, 1'b0, 1'b1, EXE_LW, 32'h2000, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b0, EXE_SW, 32'h2004, 32'h55AA_1234);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = ld_valid;
        end
        check("b2b_ld_valid_seen", seen, 1'b1);
        expect_req(1'b1, 1'b1, 1'b0, EXE_SW, 32'h2004, 32'h55AA_1234);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        idle_cycle();
        idle_cycle();
        check("b2b_sw_after_ldv", last_wr_cyc, last_ldv_cyc + 1);
        check("b2b_reads", rd_count - rd0, 1);
        check("b2b_writes", wr_count - wr0, 1);

        // Reset pulse while the load is waiting on the SRAM.
        ld0 = ld_count;
        expect_req(1'b1, 1'b0, 1'b1, EXE_LW, 32'h2004, 32'h0);
        drive(1'b1, 1'b0, 1'b1, EXE_LW, 32'h2004, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        resetn = 1'b0;
        exp_ld.delete();
        #1;
        check("midrst_ld_valid", ld_valid, 1'b0);
        check("midrst_stall", lsu_stall, 1'b0);
        #1;
        resetn = 1'b1;
        repeat (2 * LAT) idle_cycle();
        check("midrst_no_ld", ld_count - ld0, 0);
        issue_op(EXE_LW, 32'h2004, 32'h0);
        check("post_rst_ld", ld_count - ld0, 1);

        // Randomized traffic over a small window of words.
        for (int i = 0; i < 300; i++) begin
            o = ops[$urandom_range(0, 7)];
            is_st = (o == EXE_SB || o == EXE_SH || o == EXE_SW);
            n = nbytes(o);
            a = 32'h4000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 1);
            kind = $urandom_range(0, 9);
            if (kind == 0)
                issue(1'b0, is_st, !is_st, o, a, $urandom());
            else if (kind == 1)
                issue(1'b1, 1'b0, 1'b0, o, a, $urandom());
            else
                issue(1'b1, is_st, !is_st, o, a, $urandom());
            if (kind == 2) idle_cycle();
        end

        repeat (LAT + 3) idle_cycle();
        check("left_wr", exp_wr.size(), 0);
        check("left_rd", exp_rd.size(), 0);
        check("left_ld", exp_ld.size(), 0);
        check("left_err", exp_err.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
